// File: rtl/bmu_search_ctrl.sv
// Best-match search controller: streams NUM signed distances through a
// valid/ready handshake and reports the minimum and its index (last tie wins).
module bmu_search_ctrl #(
    parameter int N   = 16,
    parameter int Q   = 8,
    parameter int NUM = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dist_in,
    input  logic         dist_valid,
    output logic         dist_ready,
    output logic [2:0]   cand_idx,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] min_out,
    output logic [2:0]   min_idx
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SCAN   = 2'd2,
        FINISH = 2'd3
    } state_e;

    localparam logic [2:0] LAST_IDX = 3'(NUM - 1);

    // Q only documents the fixed-point format; ordering is plain signed compare.
    generate
        if (NUM < 2 || NUM > 8 || Q < 0 || Q >= N) begin : g_param_check
            $error("bmu_search_ctrl: illegal parameter combination");
        end
    endgenerate

    state_e         state_q, state_d;
    logic [2:0]     cand_idx_q, cand_idx_d;
    logic [N-1:0]   min_q, min_d;
    logic [2:0]     min_idx_q, min_idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cand_idx_q <= '0;
            min_q      <= '0;
            min_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            cand_idx_q <= cand_idx_d;
            min_q      <= min_d;
            min_idx_q  <= min_idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cand_idx_d = cand_idx_q;
        min_d      = min_q;
        min_idx_d  = min_idx_q;
        dist_ready = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d    = FIRST;
                    cand_idx_d = '0;
                end
            end
            FIRST: begin
                dist_ready = 1'b1;
                if (dist_valid) begin
                    min_d      = dist_in;
                    min_idx_d  = '0;
                    cand_idx_d = 3'd1;
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                dist_ready = 1'b1;
                if (dist_valid) begin
                    // <= lets a later equal sample replace the current best
                    if ($signed(dist_in) <= $signed(min_q)) begin
                        min_d     = dist_in;
                        min_idx_d = cand_idx_q;
                    end
                    if (cand_idx_q == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        cand_idx_d = cand_idx_q + 3'd1;
                    end
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_d    = IDLE;
                cand_idx_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign cand_idx = cand_idx_q;
    assign min_out  = min_q;
    assign min_idx  = min_idx_q;

    a_cand_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
        cand_idx_q <= LAST_IDX);

    a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
        done |=> !done);

endmodule
